// File: rtl/noc_pkt_pkg.sv
// noc_pkt_pkg
//   Shared NoC packet definitions: type codes, default field widths and
//   start positions, and a helper that pulls the type and source fields out
//   of a packet.
//   Field order LSB->MSB: payload, seq, source, dest, type.
package noc_pkt_pkg;

    typedef enum logic [1:0] {
        DATA          = 2'b00,
        CONF_INPUTNUM = 2'b01,
        CONF_WEIGHT   = 2'b10,
        DATA_ALT      = 2'b11   // reserved code, behaves as DATA
    } pkt_type_e;

    // Default field widths and start positions (NETWORK_SIZE = 256)
    localparam int unsigned DEF_NETWORK_SIZE  = 256;
    localparam int unsigned DEF_PAYLOAD_WIDTH = 22;
    localparam int unsigned DEF_SEQ_WIDTH     = 4;
    localparam int unsigned DEF_ADDR_WIDTH    = $clog2(DEF_NETWORK_SIZE);
    localparam int unsigned DEF_TYPE_WIDTH    = 2;
    localparam int unsigned DEF_PAYLOAD_LSB   = 0;
    localparam int unsigned DEF_SEQ_LSB       = DEF_PAYLOAD_WIDTH;
    localparam int unsigned DEF_SOURCE_LSB    = DEF_SEQ_LSB + DEF_SEQ_WIDTH;
    localparam int unsigned DEF_DEST_LSB      = DEF_SOURCE_LSB + DEF_ADDR_WIDTH;
    localparam int unsigned DEF_TYPE_LSB      = DEF_DEST_LSB + DEF_ADDR_WIDTH;

    // Containers wide enough for any supported parameterisation
    localparam int unsigned PKT_MAX_WIDTH = 128;
    localparam int unsigned SRC_MAX_WIDTH = 16;

    typedef struct packed {
        pkt_type_e                ptype;
        logic [SRC_MAX_WIDTH-1:0] src;
    } pkt_hdr_t;

    function automatic pkt_hdr_t pkt_hdr(
        input logic [PKT_MAX_WIDTH-1:0] pkt,
        input int unsigned              src_lsb,
        input int unsigned              src_width,
        input int unsigned              type_lsb
    );
        pkt_hdr_t                 hdr;
        logic [PKT_MAX_WIDTH-1:0] sh;
        logic [SRC_MAX_WIDTH-1:0] mask;
        sh        = pkt >> src_lsb;
        mask      = '1;
        mask      = mask >> (SRC_MAX_WIDTH - src_width);
        hdr.src   = sh[SRC_MAX_WIDTH-1:0] & mask;
        sh        = pkt >> type_lsb;
        hdr.ptype = pkt_type_e'(sh[1:0]);
        return hdr;
    endfunction

    function automatic logic is_data(input pkt_type_e t);
        return (t == DATA) || (t == DATA_ALT);
    endfunction

endpackage

// File: rtl/mul_input_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick. Search starts at ptr and ascends with
//   wrap; the first set request wins.
//   req    : request vector
//   ptr    : search start index (always < NUM_REQ)
//   grant  : one-hot-or-zero grant
//   winner : index of the granted request (0 when no grant)
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   winner
);

    always_comb begin
        logic             found;
        logic [PTR_W:0]   idx_sum;
        logic [PTR_W-1:0] idx;
        found   = 1'b0;
        idx_sum = '0;
        idx     = '0;
        grant   = '0;
        winner  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (idx_sum >= (PTR_W+1)'(NUM_REQ)) begin
                idx_sum = idx_sum - (PTR_W+1)'(NUM_REQ);
            end
            idx = idx_sum[PTR_W-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = idx;
            end
        end
    end

endmodule

// File: rtl/mul_input_arbiter.sv
// mul_input_arbiter
//   Shares the multiplier packet input between NUM_REQ requesters. Round-robin
//   valid/ready arbitration, registered output, and a one-cycle bubble when a
//   DATA packet would read a weight the multiplier is still writing.
//   Optional build macro: MUL_ARB_CONF_PRIORITY_EN -- eligible CONF_* packets
//   beat eligible DATA packets (round-robin within each class).
//   clk            : rising-edge clock
//   rst            : asynchronous active-low reset
//   req_valid      : per-requester valid
//   req_packet     : requester i at [i*PACKET_SIZE +: PACKET_SIZE]
//   req_ready      : combinational one-hot-or-zero grant
//   SNC_MUL_valid  : registered valid to the multiplier
//   SNC_MUL_packet : registered packet to the multiplier
//   hazard_stall   : a bubble is being forced this cycle
module mul_input_arbiter
    import noc_pkt_pkg::*;
#(
    parameter int NETWORK_SIZE  = 256,
    parameter int PAYLOAD_WIDTH = 22,
    parameter int SEQ_WIDTH     = 4,
    parameter int TYPE_WIDTH    = 2,
    parameter int NUM_REQ       = 2,
    localparam int SOURCE_WIDTH = $clog2(NETWORK_SIZE),
    localparam int DEST_WIDTH   = $clog2(NETWORK_SIZE),
    localparam int PACKET_SIZE  = PAYLOAD_WIDTH + SEQ_WIDTH + SOURCE_WIDTH
                                  + DEST_WIDTH + TYPE_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*PACKET_SIZE-1:0] req_packet,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           SNC_MUL_valid,
    output logic [PACKET_SIZE-1:0]         SNC_MUL_packet,
    output logic                           hazard_stall
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SRC_LSB  = PAYLOAD_WIDTH + SEQ_WIDTH;
    localparam int unsigned TYPE_LSB = SRC_LSB + SOURCE_WIDTH + DEST_WIDTH;

    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       winner;
    logic [NUM_REQ-1:0]     grant;
    logic [NUM_REQ-1:0]     blocked;
    logic [NUM_REQ-1:0]     elig;
    logic [NUM_REQ-1:0]     arb_req;
    logic [PACKET_SIZE-1:0] win_pkt;
    pkt_hdr_t               out_hdr;

    always_comb begin
        out_hdr = pkt_hdr(PKT_MAX_WIDTH'(SNC_MUL_packet), SRC_LSB, SOURCE_WIDTH, TYPE_LSB);
    end

    // A DATA packet from the same source as a weight presented last cycle
    // must wait one cycle: the multiplier commits that weight a cycle late.
    always_comb begin
        pkt_hdr_t hdr;
`ifdef MUL_ARB_CONF_PRIORITY_EN
        logic [NUM_REQ-1:0] conf_mask;
        conf_mask = '0;
`endif
        hdr     = '0;
        blocked = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hdr = pkt_hdr(PKT_MAX_WIDTH'(req_packet[i*PACKET_SIZE +: PACKET_SIZE]),
                          SRC_LSB, SOURCE_WIDTH, TYPE_LSB);
            blocked[i] = SNC_MUL_valid && (out_hdr.ptype == CONF_WEIGHT)
                         && is_data(hdr.ptype) && (hdr.src == out_hdr.src);
`ifdef MUL_ARB_CONF_PRIORITY_EN
            conf_mask[i] = !is_data(hdr.ptype);
`endif
        end
        elig    = req_valid & ~blocked;
        arb_req = elig;
`ifdef MUL_ARB_CONF_PRIORITY_EN
        if (|(elig & conf_mask)) begin
            arb_req = elig & conf_mask;
        end
`endif
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req    (arb_req),
        .ptr    (rr_ptr),
        .grant  (grant),
        .winner (winner)
    );

    always_comb begin
        win_pkt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_pkt = req_packet[i*PACKET_SIZE +: PACKET_SIZE];
            end
        end
    end

    // Ready is forced low while reset is held so no transfer can be counted.
    assign req_ready    = {NUM_REQ{rst}} & grant;
    assign hazard_stall = (|(req_valid & blocked)) && !(|grant);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            SNC_MUL_valid  <= 1'b0;
            SNC_MUL_packet <= '0;
            rr_ptr         <= '0;
        end else begin
            SNC_MUL_valid <= |grant;
            if (|grant) begin
                SNC_MUL_packet <= win_pkt;
                rr_ptr         <= (winner == PTR_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
            end
        end
    end

endmodule
